// File: rtl/vga_scan_gen_if.sv
// Scan-generator port bundle: run request in, timing, fetch requests and
// latency-matched timing copies out.
interface vga_scan_gen_if #(
  parameter int LOG_HCOUNT = 10,
  parameter int LOG_VCOUNT = 10,
  parameter int LOG_PPW    = 1
);
  logic                             run;
  logic                             busy;
  logic [LOG_HCOUNT-1:0]            hcount;
  logic [LOG_VCOUNT-1:0]            vcount;
  logic                             frame_start;
  logic                             frame_done;
  logic                             hsync;
  logic                             vsync;
  logic                             blank;
  logic                             fetch_req;
  logic [LOG_HCOUNT-LOG_PPW-1:0]    fetch_word;
  logic [LOG_VCOUNT-1:0]            fetch_line;
  logic                             del_hsync;
  logic                             del_vsync;
  logic                             del_blank;
  logic [LOG_PPW-1:0]               del_sub;

  modport master (
    input  run,
    output busy, hcount, vcount, frame_start, frame_done,
    output hsync, vsync, blank, fetch_req, fetch_word, fetch_line,
    output del_hsync, del_vsync, del_blank, del_sub
  );

  modport slave (
    output run,
    input  busy, hcount, vcount, frame_start, frame_done,
    input  hsync, vsync, blank, fetch_req, fetch_word, fetch_line,
    input  del_hsync, del_vsync, del_blank, del_sub
  );
endinterface

// File: rtl/vga_scan_gen.sv
// Parametrised VGA scan generator: counters, registered sync/blank/fetch decode,
// memory-latency-matched delay line, and a run/drain FSM that stops on frame ends.
module vga_scan_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 11,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 31,
  parameter int SYNC_POL   = 0,
  parameter int DELAY      = 7,
  parameter int LOG_PPW    = 1,
  parameter int LOG_HCOUNT = 10,
  parameter int LOG_VCOUNT = 10
) (
  input  logic           vclock,
  input  logic           reset,
  vga_scan_gen_if.master scan
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FW      = LOG_HCOUNT - LOG_PPW;

  localparam logic [LOG_HCOUNT-1:0] H_LAST   = LOG_HCOUNT'(H_TOTAL - 1);
  localparam logic [LOG_HCOUNT-1:0] H_ACT    = LOG_HCOUNT'(H_ACTIVE);
  localparam logic [LOG_HCOUNT-1:0] HS_START = LOG_HCOUNT'(H_ACTIVE + H_FP);
  localparam logic [LOG_HCOUNT-1:0] HS_END   = LOG_HCOUNT'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [LOG_VCOUNT-1:0] V_LAST   = LOG_VCOUNT'(V_TOTAL - 1);
  localparam logic [LOG_VCOUNT-1:0] V_ACT    = LOG_VCOUNT'(V_ACTIVE);
  localparam logic [LOG_VCOUNT-1:0] VS_START = LOG_VCOUNT'(V_ACTIVE + V_FP);
  localparam logic [LOG_VCOUNT-1:0] VS_END   = LOG_VCOUNT'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_OFF = (SYNC_POL == 0);
  localparam logic SYNC_ON  = !SYNC_OFF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // One delay-line stage: everything the pixel path needs alongside returned data.
  typedef struct packed {
    logic               hs;
    logic               vs;
    logic               blank;
    logic [LOG_PPW-1:0] sub;
  } tap_t;

  localparam tap_t TAP_RESET = {SYNC_OFF, SYNC_OFF, 1'b1, {LOG_PPW{1'b0}}};

  state_t                state_reg, state_next;
  logic [LOG_HCOUNT-1:0] hcount_reg, hcount_next;
  logic [LOG_VCOUNT-1:0] vcount_reg, vcount_next;
  logic                  h_last, v_last, frame_done_c;
  logic                  blank_c, hsync_c, vsync_c, fetch_c;

  logic                  hsync_reg, vsync_reg, blank_reg, fetch_req_reg;
  logic [FW-1:0]         fetch_word_reg;
  logic [LOG_VCOUNT-1:0] fetch_line_reg;
  logic [LOG_PPW-1:0]    sub_reg;
  tap_t                  tap_pipe_reg [DELAY];

  always_comb begin
    h_last       = (hcount_reg == H_LAST);
    v_last       = (vcount_reg == V_LAST);
    frame_done_c = (state_reg != S_IDLE) && h_last && v_last;

    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (scan.run) state_next = S_RUN;
      S_RUN:   if (!scan.run) state_next = S_DRAIN;
      // A renewed run request cancels the pending stop without touching the counts.
      S_DRAIN: if (scan.run) state_next = S_RUN;
               else if (frame_done_c) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    hcount_next = '0;
    vcount_next = '0;
    if (state_reg != S_IDLE) begin
      if (h_last) begin
        hcount_next = '0;
        vcount_next = v_last ? '0 : vcount_reg + 1'b1;
      end else begin
        hcount_next = hcount_reg + 1'b1;
        vcount_next = vcount_reg;
      end
    end

    blank_c = (state_reg == S_IDLE) || (hcount_reg >= H_ACT) || (vcount_reg >= V_ACT);
    hsync_c = (state_reg != S_IDLE) && (hcount_reg >= HS_START) && (hcount_reg < HS_END);
    vsync_c = (state_reg != S_IDLE) && (vcount_reg >= VS_START) && (vcount_reg < VS_END);
    fetch_c = !blank_c && (hcount_reg[LOG_PPW-1:0] == '0);
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      hcount_reg     <= '0;
      vcount_reg     <= '0;
      hsync_reg      <= SYNC_OFF;
      vsync_reg      <= SYNC_OFF;
      blank_reg      <= 1'b1;
      fetch_req_reg  <= 1'b0;
      fetch_word_reg <= '0;
      fetch_line_reg <= '0;
      sub_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      hcount_reg     <= hcount_next;
      vcount_reg     <= vcount_next;
      hsync_reg      <= hsync_c ? SYNC_ON : SYNC_OFF;
      vsync_reg      <= vsync_c ? SYNC_ON : SYNC_OFF;
      blank_reg      <= blank_c;
      fetch_req_reg  <= fetch_c;
      fetch_word_reg <= hcount_reg[LOG_HCOUNT-1:LOG_PPW];
      fetch_line_reg <= vcount_reg;
      sub_reg        <= hcount_reg[LOG_PPW-1:0];
    end
  end

  // Keeps shifting in IDLE so the tail of the final frame still reaches the pixel path.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DELAY; i++) tap_pipe_reg[i] <= TAP_RESET;
    end else begin
      tap_pipe_reg[0] <= {hsync_reg, vsync_reg, blank_reg, sub_reg};
      for (int i = 1; i < DELAY; i++) tap_pipe_reg[i] <= tap_pipe_reg[i-1];
    end
  end

  assign scan.busy        = (state_reg != S_IDLE);
  assign scan.hcount      = hcount_reg;
  assign scan.vcount      = vcount_reg;
  assign scan.frame_start = (state_reg == S_RUN) && (hcount_reg == '0) && (vcount_reg == '0);
  assign scan.frame_done  = frame_done_c;
  assign scan.hsync       = hsync_reg;
  assign scan.vsync       = vsync_reg;
  assign scan.blank       = blank_reg;
  assign scan.fetch_req   = fetch_req_reg;
  assign scan.fetch_word  = fetch_word_reg;
  assign scan.fetch_line  = fetch_line_reg;
  assign scan.del_hsync   = tap_pipe_reg[DELAY-1].hs;
  assign scan.del_vsync   = tap_pipe_reg[DELAY-1].vs;
  assign scan.del_blank   = tap_pipe_reg[DELAY-1].blank;
  assign scan.del_sub     = tap_pipe_reg[DELAY-1].sub;
endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: instance A uses default horizontal timing with a
// short frame, instance B the alternate parameter set (active-high sync, 4 px/word).
module tb_vga_scan_gen;
  localparam int X = -1;   // don't-care marker in the vector table
  localparam int NF = 13;

  logic vclock = 1'b0;
  logic reset_a, reset_b;
  always #5 vclock = ~vclock;

  vga_scan_gen_if #(.LOG_HCOUNT(10), .LOG_VCOUNT(10), .LOG_PPW(1)) ifa ();
  vga_scan_gen_if #(.LOG_HCOUNT(10), .LOG_VCOUNT(10), .LOG_PPW(2)) ifb ();

  vga_scan_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_a (
    .vclock(vclock), .reset(reset_a), .scan(ifa));

  vga_scan_gen #(.H_ACTIVE(320), .H_FP(8), .H_SYNC(48), .H_BP(24),
                 .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                 .SYNC_POL(1), .DELAY(3), .LOG_PPW(2)) dut_b (
    .vclock(vclock), .reset(reset_b), .scan(ifb));

  typedef struct {
    string name;
    bit    inst;
    int    k;
    int    e [NF];  // hc vc fs fd hs vs bl fr fw fl db dh ds
  } vec_t;

  string fname [NF] = '{"hcount", "vcount", "frame_start", "frame_done", "hsync", "vsync",
                        "blank", "fetch_req", "fetch_word", "fetch_line", "del_blank",
                        "del_hsync", "del_sub"};

  int n_cmp = 0, n_bad = 0;
  int k_a = 0, k_b = 0;
  int req_a = 0, req_b = 0, frame_req_a = -1, frame_req_b = -1;
  int word_a = 0, word_b = 0, viol_a = 0, viol_b = 0;
  vec_t vecs [$];

  function automatic vec_t mk(string n, bit inst, int k, int hc, int vc, int fs, int fd,
                              int hs, int vs, int bl, int fr, int fw, int fl,
                              int db, int dh, int ds);
    vec_t v;
    v.name = n; v.inst = inst; v.k = k;
    v.e = '{hc, vc, fs, fd, hs, vs, bl, fr, fw, fl, db, dh, ds};
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic apply(input vec_t v);
    int act [NF];
    if (v.inst == 1'b0)
      act = '{int'(ifa.hcount), int'(ifa.vcount), int'(ifa.frame_start), int'(ifa.frame_done),
              int'(ifa.hsync), int'(ifa.vsync), int'(ifa.blank), int'(ifa.fetch_req),
              int'(ifa.fetch_word), int'(ifa.fetch_line), int'(ifa.del_blank),
              int'(ifa.del_hsync), int'(ifa.del_sub)};
    else
      act = '{int'(ifb.hcount), int'(ifb.vcount), int'(ifb.frame_start), int'(ifb.frame_done),
              int'(ifb.hsync), int'(ifb.vsync), int'(ifb.blank), int'(ifb.fetch_req),
              int'(ifb.fetch_word), int'(ifb.fetch_line), int'(ifb.del_blank),
              int'(ifb.del_hsync), int'(ifb.del_sub)};
    for (int i = 0; i < NF; i++)
      if (v.e[i] >= 0) chk($sformatf("%s.%s", v.name, fname[i]), act[i], v.e[i]);
  endtask

  // One cycle; also tallies fetch requests per frame and checks the word sequence.
  task automatic step();
    @(negedge vclock);
    k_a++; k_b++;
    if (ifa.frame_start) begin frame_req_a = req_a; req_a = 0; end
    if (ifb.frame_start) begin frame_req_b = req_b; req_b = 0; end
    if (ifa.fetch_req) begin
      req_a++;
      if (ifa.blank || int'(ifa.fetch_word) != word_a) viol_a++;
      word_a = (word_a == 319) ? 0 : word_a + 1;
    end
    if (ifb.fetch_req) begin
      req_b++;
      if (ifb.blank || int'(ifb.fetch_word) != word_b) viol_b++;
      word_b = (word_b == 79) ? 0 : word_b + 1;
    end
  endtask

  task automatic wait_evt(input bit inst, input bit on_done, input int lim, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < lim) begin
      step();
      n++;
      if (inst == 1'b0) hit = on_done ? ifa.frame_done : ifa.frame_start;
      else              hit = on_done ? ifb.frame_done : ifb.frame_start;
    end
    if (!hit) n = -1;
  endtask

  initial begin
    int n;
    //               name          i  k     hc   vc  fs fd hs vs bl fr fw   fl db dh ds
    vecs.push_back(mk("a_k0",        0, 0,    0,   0, 1, 0, 1, 1, 1, 0, X,   X, 1, 1, 0));
    vecs.push_back(mk("a_first_px",  0, 1,    1,   0, 0, 0, 1, 1, 0, 1, 0,   0, 1, 1, 0));
    vecs.push_back(mk("a_odd_px",    0, 2,    2,   0, X, X, X, X, 0, 0, X,   X, X, X, X));
    vecs.push_back(mk("a_word1",     0, 3,    X,   X, X, X, X, X, 0, 1, 1,   X, X, X, X));
    vecs.push_back(mk("a_del_hi",    0, 7,    X,   X, X, X, X, X, X, X, X,   X, 1, X, X));
    vecs.push_back(mk("a_del_lo",    0, 8,    X,   X, X, X, X, X, X, X, X,   X, 0, X, 0));
    vecs.push_back(mk("a_sub1",      0, 9,    X,   X, X, X, X, X, X, X, X,   X, 0, X, 1));
    vecs.push_back(mk("a_sub0",      0, 10,   X,   X, X, X, X, X, X, X, X,   X, X, X, 0));
    vecs.push_back(mk("a_last_word", 0, 639,  X,   X, X, X, X, X, 0, 1, 319, 0, X, X, X));
    vecs.push_back(mk("a_act_end",   0, 640,  X,   X, X, X, X, X, 0, 0, X,   X, X, X, X));
    vecs.push_back(mk("a_hblank",    0, 641,  X,   X, X, X, 1, X, 1, 0, X,   X, X, X, X));
    vecs.push_back(mk("a_hs_pre",    0, 656,  X,   X, X, X, 1, X, X, X, X,   X, X, X, X));
    vecs.push_back(mk("a_hs_first",  0, 657,  X,   X, X, X, 0, X, 1, X, X,   X, X, 1, X));
    vecs.push_back(mk("a_dhs_pre",   0, 663,  X,   X, X, X, X, X, X, X, X,   X, X, 1, X));
    vecs.push_back(mk("a_dhs_first", 0, 664,  X,   X, X, X, X, X, X, X, X,   X, X, 0, X));
    vecs.push_back(mk("a_hs_last",   0, 752,  X,   X, X, X, 0, X, X, X, X,   X, X, X, X));
    vecs.push_back(mk("a_hs_end",    0, 753,  X,   X, X, X, 1, X, X, X, X,   X, X, X, X));
    vecs.push_back(mk("a_line_wrap", 0, 800,  0,   1, 0, X, X, X, 1, X, X,   X, X, X, X));
    vecs.push_back(mk("a_line1",     0, 801,  1,   1, X, X, X, X, 0, 1, 0,   1, X, X, X));
    vecs.push_back(mk("a_vblank",    0, 3201, 1,   4, X, X, X, X, 1, 0, X,   X, X, X, X));
    vecs.push_back(mk("a_vs_pre",    0, 4800, 0,   6, X, X, X, 1, X, X, X,   X, X, X, X));
    vecs.push_back(mk("a_vs_first",  0, 4801, X,   X, X, X, X, 0, 1, X, X,   X, X, X, X));
    vecs.push_back(mk("a_vs_last",   0, 6400, 0,   8, X, X, X, 0, X, X, X,   X, X, X, X));
    vecs.push_back(mk("a_vs_end",    0, 6401, X,   X, X, X, X, 1, X, X, X,   X, X, X, X));
    vecs.push_back(mk("a_frm_done",  0, 7999, 799, 9, 0, 1, X, X, X, X, X,   X, X, X, X));
    vecs.push_back(mk("a_frame2",    0, 8000, 0,   0, 1, 0, X, X, 1, X, X,   X, X, X, X));
    vecs.push_back(mk("a_frame2_px", 0, 8001, X,   X, X, X, X, X, 0, 1, 0,   X, X, X, X));
    vecs.push_back(mk("b_k0",        1, 0,    0,   0, 1, 0, 0, 0, 1, 0, X,   X, 1, 0, 0));
    vecs.push_back(mk("b_first_px",  1, 1,    X,   X, X, X, 0, X, 0, 1, 0,   0, X, X, X));
    vecs.push_back(mk("b_px1",       1, 2,    X,   X, X, X, X, X, 0, 0, X,   X, X, X, X));
    vecs.push_back(mk("b_del_hi",    1, 3,    X,   X, X, X, X, X, X, X, X,   X, 1, X, X));
    vecs.push_back(mk("b_del_lo",    1, 4,    X,   X, X, X, X, X, X, X, X,   X, 0, X, 0));
    vecs.push_back(mk("b_word1",     1, 5,    X,   X, X, X, X, X, X, 1, 1,   X, X, X, 1));
    vecs.push_back(mk("b_sub2",      1, 6,    X,   X, X, X, X, X, X, X, X,   X, X, X, 2));
    vecs.push_back(mk("b_sub3",      1, 7,    X,   X, X, X, X, X, X, X, X,   X, X, X, 3));
    vecs.push_back(mk("b_sub_wrap",  1, 8,    X,   X, X, X, X, X, X, X, X,   X, X, X, 0));
    vecs.push_back(mk("b_last_word", 1, 317,  X,   X, X, X, X, X, 0, 1, 79,  X, X, X, X));
    vecs.push_back(mk("b_hblank",    1, 321,  X,   X, X, X, X, X, 1, 0, X,   X, X, X, X));
    vecs.push_back(mk("b_hs_pre",    1, 328,  X,   X, X, X, 0, X, X, X, X,   X, X, X, X));
    vecs.push_back(mk("b_hs_first",  1, 329,  X,   X, X, X, 1, X, X, X, X,   X, X, X, X));
    vecs.push_back(mk("b_dhs_pre",   1, 331,  X,   X, X, X, X, X, X, X, X,   X, X, 0, X));
    vecs.push_back(mk("b_dhs_first", 1, 332,  X,   X, X, X, X, X, X, X, X,   X, X, 1, X));
    vecs.push_back(mk("b_hs_last",   1, 376,  X,   X, X, X, 1, X, X, X, X,   X, X, X, X));
    vecs.push_back(mk("b_hs_end",    1, 377,  X,   X, X, X, 0, X, X, X, X,   X, X, X, X));
    vecs.push_back(mk("b_vs_pre",    1, 1600, 0,   4, X, X, X, 0, X, X, X,   X, X, X, X));
    vecs.push_back(mk("b_vs_first",  1, 1601, X,   X, X, X, X, 1, 1, X, X,   X, X, X, X));
    vecs.push_back(mk("b_vs_end",    1, 2001, X,   X, X, X, X, 0, X, X, X,   X, X, X, X));
    vecs.push_back(mk("b_frm_done",  1, 2399, 399, 5, 0, 1, X, X, X, X, X,   X, X, X, X));
    vecs.push_back(mk("b_frame2",    1, 2400, 0,   0, 1, 0, X, X, X, X, X,   X, X, X, X));

    reset_a = 1'b1; reset_b = 1'b1;
    ifa.run = 1'b0; ifb.run = 1'b0;
    repeat (3) @(negedge vclock);
    reset_a = 1'b0; reset_b = 1'b0;
    @(negedge vclock);
    apply(mk("a_reset", 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0));
    chk("a_reset.busy", int'(ifa.busy), 0);
    apply(mk("b_reset", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));

    // Instance A: first frame, decode checks, second frame start.
    ifa.run = 1'b1;
    wait_evt(1'b0, 1'b0, 10, n);
    chk("a_start_latency", n, 1);
    k_a = 0;
    foreach (vecs[i]) if (vecs[i].inst == 1'b0) begin
      while (k_a < vecs[i].k) step();
      apply(vecs[i]);
    end
    chk("a_reqs_per_frame", frame_req_a, 1280);

    // Stop mid-frame: busy until the frame ends, then idle and blank.
    while (k_a < 9000) step();
    ifa.run = 1'b0;
    step();
    chk("a_drain.busy", int'(ifa.busy), 1);
    wait_evt(1'b0, 1'b1, 8000, n);
    chk("a_drain.done_at", k_a, 15999);
    step();
    apply(mk("a_stopped", 0, 0, 0, 0, 0, 0, X, X, 1, 0, X, X, X, X, X));
    chk("a_stopped.busy", int'(ifa.busy), 0);
    repeat (10) step();
    apply(mk("a_idle", 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, X, X, 1, 1, X));
    chk("a_idle.busy", int'(ifa.busy), 0);

    // One-cycle run pulse in IDLE: one full frame then drain.
    ifa.run = 1'b1;
    wait_evt(1'b0, 1'b0, 10, n);
    ifa.run = 1'b0;
    chk("a_pulse.start", n, 1);
    k_a = 0;
    wait_evt(1'b0, 1'b1, 9000, n);
    chk("a_pulse.done_at", k_a, 7999);
    step();
    chk("a_pulse.busy_after", int'(ifa.busy), 0);

    // Stop then resume inside the same frame: no gap into the next frame.
    ifa.run = 1'b1;
    wait_evt(1'b0, 1'b0, 10, n);
    k_a = 0;
    repeat (100) step();
    ifa.run = 1'b0;
    repeat (100) step();
    chk("a_resume.busy_drain", int'(ifa.busy), 1);
    ifa.run = 1'b1;
    wait_evt(1'b0, 1'b1, 9000, n);
    chk("a_resume.done_at", k_a, 7999);
    step();
    chk("a_resume.frame_start", int'(ifa.frame_start), 1);
    chk("a_resume.busy", int'(ifa.busy), 1);
    ifa.run = 1'b0;

    // Instance B: alternate parameter set.
    ifb.run = 1'b1;
    wait_evt(1'b1, 1'b0, 10, n);
    chk("b_start_latency", n, 1);
    k_b = 0;
    foreach (vecs[i]) if (vecs[i].inst == 1'b1) begin
      while (k_b < vecs[i].k) step();
      apply(vecs[i]);
    end
    chk("b_reqs_per_frame", frame_req_b, 240);

    // Asynchronous reset mid-line (counts 350,1) takes effect before the next edge.
    while (k_b < 3150) step();
    apply(mk("b_pre_reset", 1, 0, 350, 1, X, X, 1, X, X, X, 87, 1, X, X, 2));
    #2 reset_b = 1'b1;
    ifb.run = 1'b0;
    #1;
    apply(mk("b_async_reset", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    chk("b_async_reset.busy", int'(ifb.busy), 0);
    @(negedge vclock);
    reset_b = 1'b0;
    word_b = 0;
    repeat (3) step();
    chk("b_post_reset.busy", int'(ifb.busy), 0);
    chk("b_post_reset.hcount", int'(ifb.hcount), 0);

    chk("a_fetch_seq_violations", viol_a, 0);
    chk("b_fetch_seq_violations", viol_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
